// File: rtl/rom_line_prefetch_pkg.sv
// Shared definitions for the image-ROM line prefetcher.
//   IMG_ADDR_W / IMG_DATA_W : ROM address and data widths
//   IMG_COLS / IMG_ROWS     : image geometry (64x64 bytes)
//   pf_state_t              : prefetch FSM states
//   in_window()             : 16-bit unsigned window test, start <= pos < start+span
package rom_line_prefetch_pkg;

    localparam int IMG_ADDR_W = 12;
    localparam int IMG_DATA_W = 8;
    localparam int IMG_COLS   = 64;
    localparam int IMG_ROWS   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } pf_state_t;

    function automatic logic in_window(input logic [15:0] pos,
                                       input logic [15:0] start,
                                       input logic [15:0] span);
        logic [15:0] stop;
        stop = start + span;
        return (pos >= start) && (pos < stop);
    endfunction

endpackage

// File: rtl/rom_line_prefetch_if.sv
// ROM and host read bus of the line prefetcher.
//   rom_ad/rom_ce/rom_data          : single-port image ROM, 1-cycle read latency
//   host_req/host_addr              : host read request, held until granted
//   host_gnt/host_rvalid/host_rdata : grant pulse and read data one cycle later
// master = prefetcher side, slave = ROM + host side.
interface rom_line_prefetch_if;
    import rom_line_prefetch_pkg::*;

    logic [IMG_ADDR_W-1:0] rom_ad;
    logic                  rom_ce;
    logic [IMG_DATA_W-1:0] rom_data;
    logic                  host_req;
    logic [IMG_ADDR_W-1:0] host_addr;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [IMG_DATA_W-1:0] host_rdata;

    modport master (
        output rom_ad, rom_ce, host_gnt, host_rvalid, host_rdata,
        input  rom_data, host_req, host_addr
    );

    modport slave (
        input  rom_ad, rom_ce, host_gnt, host_rvalid, host_rdata,
        output rom_data, host_req, host_addr
    );

endinterface

// File: rtl/rom_line_prefetch_line_buf.sv
// Double-buffered line store: two 64x8 banks, one write port, one registered
// read port. The bank select bit forms the top address bit.
//   clk                       : clock
//   wr_en/wr_bank/wr_addr/wr_data : write port
//   rd_bank/rd_addr           : read address, rd_data valid next cycle
module rom_line_prefetch_line_buf
    import rom_line_prefetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [5:0]            wr_addr,
    input  logic [IMG_DATA_W-1:0] wr_data,
    input  logic                  rd_bank,
    input  logic [5:0]            rd_addr,
    output logic [IMG_DATA_W-1:0] rd_data
);

    logic [IMG_DATA_W-1:0] mem [0:2*IMG_COLS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/rom_line_prefetch.sv
// Fetches the image row needed by the next display line into the back half of
// a double-buffered line store, swaps halves at line start, and serves the
// current line's pixels from the front half. Host reads share the ROM when
// the prefetcher is idle.
//   clk, rst (async, active high)
//   x, y          : pixel / line counters
//   bus (master)  : ROM port and host read port
//   pix_data/pix_valid : registered image byte and window flag
//   busy          : FSM not IDLE
//   underrun      : sticky, line start reached while a fetch was in flight
module rom_line_prefetch
    import rom_line_prefetch_pkg::*;
#(
    parameter logic [15:0] START_X     = 16'd16,
    parameter logic [15:0] START_Y     = 16'd16,
    parameter int          SCALE_SHIFT = 2,
    parameter logic [15:0] FETCH_X     = 16'd500
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           x,
    input  logic [15:0]           y,
    rom_line_prefetch_if.master   bus,
    output logic [IMG_DATA_W-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  busy,
    output logic                  underrun
);

    localparam logic [15:0] IMG_SPAN = 16'(IMG_COLS << SCALE_SHIFT);

    pf_state_t state, state_nxt;

    logic [15:0]           y_next;
    logic [5:0]            col, row_next;
    logic                  x_in, y_in, yn_in;
    logic                  trigger, line_start, front_hit, start_fetch;
    logic [5:0]            k, fetch_row;
    logic                  front_sel, back_sel;
    logic [1:0][5:0]       tag;
    logic [1:0]            tag_vld;
    logic                  wr_en_q;
    logic [5:0]            wr_addr_q;
    logic                  rvalid_q;
    logic                  pix_on_q;
    logic [IMG_DATA_W-1:0] rd_data;
    logic                  rom_ce_c, host_gnt_c;
    logic [IMG_ADDR_W-1:0] rom_ad_c;

    // Window and index maths; the row index is for the line after this one.
    assign y_next     = y + 16'd1;
    assign col        = 6'((x - START_X) >> SCALE_SHIFT);
    assign row_next   = 6'((y_next - START_Y) >> SCALE_SHIFT);
    assign x_in       = in_window(x, START_X, IMG_SPAN);
    assign y_in       = in_window(y, START_Y, IMG_SPAN);
    assign yn_in      = in_window(y_next, START_Y, IMG_SPAN);
    assign trigger    = (x == FETCH_X) && yn_in;
    assign line_start = (x == 16'd0);
    assign back_sel   = ~front_sel;
    assign front_hit  = tag_vld[front_sel] && (tag[front_sel] == row_next);
    assign start_fetch = (state == IDLE) && trigger && !front_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_fetch) state_nxt = FETCH;
            FETCH:   if (k == 6'd63) state_nxt = DRAIN;
            DRAIN:   state_nxt = READY;
            READY:   if (line_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ROM port belongs to the fetch, otherwise to the host when no
    // trigger is pending in this cycle.
    always_comb begin
        rom_ce_c   = 1'b0;
        rom_ad_c   = '0;
        host_gnt_c = 1'b0;
        case (state)
            FETCH: begin
                rom_ce_c = 1'b1;
                rom_ad_c = {fetch_row, k};
            end
            IDLE: begin
                if (bus.host_req && !trigger) begin
                    host_gnt_c = 1'b1;
                    rom_ce_c   = 1'b1;
                    rom_ad_c   = bus.host_addr;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    // Counter, tags, buffer select and registered side paths
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            fetch_row <= '0;
            front_sel <= 1'b0;
            tag       <= '0;
            tag_vld   <= '0;
            underrun  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            rvalid_q  <= 1'b0;
            pix_on_q  <= 1'b0;
            pix_valid <= 1'b0;
        end else begin
            // ROM data arrives one cycle after the address: write lags by one.
            wr_en_q   <= (state == FETCH);
            wr_addr_q <= k;
            rvalid_q  <= host_gnt_c;

            if (start_fetch) begin
                fetch_row         <= row_next;
                k                 <= '0;
                tag_vld[back_sel] <= 1'b0;
            end else if (state == FETCH) begin
                k <= k + 6'd1;
            end

            if (state == DRAIN) begin
                tag[back_sel]     <= fetch_row;
                tag_vld[back_sel] <= 1'b1;
            end

            if (line_start) begin
                if (state == READY) begin
                    front_sel <= ~front_sel;
                end else if (state == FETCH || state == DRAIN) begin
                    underrun <= 1'b1;
                end
            end

            pix_valid <= x_in && y_in;
            pix_on_q  <= x_in && y_in && tag_vld[front_sel];
        end
    end

    rom_line_prefetch_line_buf u_line_buf (
        .clk     (clk),
        .wr_en   (wr_en_q),
        .wr_bank (back_sel),
        .wr_addr (wr_addr_q),
        .wr_data (bus.rom_data),
        .rd_bank (front_sel),
        .rd_addr (col),
        .rd_data (rd_data)
    );

    assign pix_data        = pix_on_q ? rd_data : '0;
    assign bus.rom_ce      = rom_ce_c;
    assign bus.rom_ad      = rom_ad_c;
    assign bus.host_gnt    = host_gnt_c;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = rvalid_q ? bus.rom_data : '0;

endmodule
